spwm_frame_rx: RTL
==================

SPWM_FRAME_RX -- requirements
Module: spwm_frame_rx

Parameters
REQ-001 HDR0, 8'hA5, first header byte.
REQ-002 HDR1, 8'h5A, second header byte.
REQ-003 TIMEOUT_CYC, 16'd50000, maximum clk cycles allowed between bytes inside a frame.
REQ-004 FIFO_DEPTH, 256, depth of the downstream command FIFO.

Interface
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 rx_data  in  8  received byte, valid when rx_valid=1.
REQ-008 rx_valid  in  1  one-cycle strobe per received byte.
REQ-009 wrfifo_data  out  8  byte written to the command FIFO.
REQ-010 wrfifo_req  out  1  FIFO write enable; one byte written per high cycle.
REQ-011 wrfifo_usedw  in  9  current FIFO fill level, in words.
REQ-012 frame_ok  out  1  one-cycle pulse after a frame's 12th byte is written.
REQ-013 frame_err  out  1  one-cycle pulse on a checksum mismatch.
REQ-014 timeout_err  out  1  one-cycle pulse on an inter-byte timeout.
REQ-015 ovf_err  out  1  one-cycle pulse when a byte is dropped while in WAIT_SPACE or WRITE.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 Frame format: HDR0, HDR1, 12 payload bytes, then CHK.
  - Payload order: cyc1_hi, cyc1_lo, ph1_hi, ph1_lo, cyc2_hi, cyc2_lo, ph2_hi, ph2_lo, cyc3_hi, cyc3_lo, ph3_hi, ph3_lo.
  - CHK = 8-bit modulo-256 sum of the 12 payload bytes.
REQ-018 States: IDLE, HDR, PAYLOAD, CHK, WAIT_SPACE, WRITE (one-hot).
REQ-019 IDLE: rx byte == HDR0 -> HDR; any other byte is ignored.
REQ-020 HDR:
  - byte == HDR1 -> PAYLOAD; clear the index and the sum.
  - byte == HDR0 -> stay in HDR.
  - any other byte -> IDLE.
REQ-021 PAYLOAD:
  - Store each byte in buf[idx].
  - sum <= sum + byte, truncated to 8 bits.
  - After idx 11 -> CHK.
REQ-022 CHK:
  - byte == sum -> WAIT_SPACE.
  - otherwise pulse frame_err and go to IDLE; no FIFO write occurs.
REQ-023 WAIT_SPACE: when wrfifo_usedw <= FIFO_DEPTH-12 -> WRITE.
REQ-024 WRITE:
  - wrfifo_req is high for exactly 12 consecutive cycles, presenting buf[0]..buf[11] in order, data valid in the same cycle as req.
  - The downstream reader consumes back-to-back, so gaps within the burst are forbidden.
REQ-025 The cycle after the last WRITE beat: frame_ok=1 for one cycle and state -> IDLE.
REQ-026 rx_valid during WAIT_SPACE or WRITE: the byte is dropped, ovf_err pulses, and the burst is unaffected.
REQ-027 Timeout counter:
  - Resets on every rx_valid.
  - Increments in HDR, PAYLOAD and CHK.
  - Reaching TIMEOUT_CYC -> IDLE with a one-cycle timeout_err pulse.
  - Inactive in IDLE, WAIT_SPACE and WRITE.
REQ-028 rx_valid in the same cycle the timeout fires: the timeout wins and the byte is discarded.
REQ-029 Latency: the first wrfifo_req occurs no earlier than 1 cycle after the CHK byte; worst case is 2 cycles when space is already available.
REQ-030 The index counter is 4 bits, compared exactly against 11, and never wraps.
REQ-031 Only one error pulse fires per cycle; each pulse lasts exactly one cycle.

Reset
REQ-032 While reset_n=0:
  - state=IDLE.
  - wrfifo_req=0, wrfifo_data=0.
  - frame_ok, frame_err, timeout_err, ovf_err, busy = 0.
  - idx, sum, timeout counter and buf are all cleared.
REQ-033 Reset asserted mid-frame or mid-burst stops wrfifo_req immediately (asynchronously), and the partial frame is discarded.
REQ-034 After reset release, the block accepts a frame starting with the next HDR0 byte.

Verification
REQ-035 Good frame: A5 5A 00 64 00 00 00 64 01 55 00 64 02 AA 2E, usedw=0.
  - 12 consecutive req cycles with bytes 00,64,...,AA.
  - frame_ok pulses once.
REQ-036 Same frame with CHK=2F: frame_err pulses once, wrfifo_req never asserts, and the block returns to IDLE.
REQ-037 Header resync: stream A5 A5 5A followed by a good payload and CHK -> frame accepted and written.
REQ-038 Space stall: usedw=245 at CHK -> no req, block stays in WAIT_SPACE; drop usedw to 244 -> 12-beat burst follows.
  - Bytes sent during the stall each pulse ovf_err.
REQ-039 Timeout: A5 5A 00 64, then idle for 50000 cycles -> timeout_err pulses, busy=0, and the next full frame is accepted.
REQ-040 Reset mid-burst (after beat 5): wrfifo_req=0 immediately and no frame_ok; the following good frame writes a full 12-beat burst.

Source files
------------

// File: rtl/spwm_frame_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spwm_frame_rx_if : byte receive strobe, FIFO write port and status    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface spwm_frame_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] wrfifo_data;
  logic       wrfifo_req;
  logic [8:0] wrfifo_usedw;
  logic       frame_ok;
  logic       frame_err;
  logic       timeout_err;
  logic       ovf_err;
  logic       busy;

  modport master (
    output rx_data, rx_valid, wrfifo_usedw,
    input  wrfifo_data, wrfifo_req, frame_ok, frame_err, timeout_err, ovf_err, busy
  );

  modport slave (
    input  rx_data, rx_valid, wrfifo_usedw,
    output wrfifo_data, wrfifo_req, frame_ok, frame_err, timeout_err, ovf_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/spwm_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spwm_frame_rx : parses A5 5A + 12 payload + checksum frames and       |
// | bursts the payload into the command FIFO.           Rev 1.0           |
// +----------------------------------------------------------------------+
module spwm_frame_rx #(
  parameter logic [7:0]  HDR0        = 8'hA5,
  parameter logic [7:0]  HDR1        = 8'h5A,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter int          FIFO_DEPTH  = 256
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  spwm_frame_rx_if.slave      bus
);

  localparam logic [8:0]  SPACE_LIMIT = 9'(FIFO_DEPTH - 12);
  localparam logic [3:0]  LAST_IDX    = 4'd11;
  localparam logic [15:0] TMO_LAST    = TIMEOUT_CYC - 16'd1;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_HDR     = 6'b000010,
    S_PAYLOAD = 6'b000100,
    S_CHK     = 6'b001000,
    S_WAIT    = 6'b010000,
    S_WRITE   = 6'b100000
  } state_t;

  state_t      state_q;
  logic [3:0]  idx_q;
  logic [7:0]  sum_q;
  logic [15:0] tcnt_q;
  logic [7:0]  pbuf_q [12];
  logic [7:0]  wr_data_q;
  logic        wr_req_q;
  logic        frame_ok_q;
  logic        frame_err_q;
  logic        timeout_err_q;
  logic        ovf_err_q;

  logic w_active;
  logic w_timeout;

  assign w_active  = (state_q == S_HDR) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  // The timeout takes priority over a byte arriving in the same cycle.
  assign w_timeout = w_active && (tcnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      idx_q         <= 4'd0;
      sum_q         <= 8'd0;
      tcnt_q        <= 16'd0;
      wr_data_q     <= 8'd0;
      wr_req_q      <= 1'b0;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      ovf_err_q     <= 1'b0;
      for (int i = 0; i < 12; i++) pbuf_q[i] <= 8'd0;
    end else begin
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      ovf_err_q     <= 1'b0;

      if (w_timeout) begin
        state_q       <= S_IDLE;
        timeout_err_q <= 1'b1;
        tcnt_q        <= 16'd0;
      end else begin
        if (bus.rx_valid || !w_active) tcnt_q <= 16'd0;
        else                           tcnt_q <= tcnt_q + 16'd1;

        case (state_q)
          S_IDLE: begin
            if (bus.rx_valid && bus.rx_data == HDR0) state_q <= S_HDR;
          end

          S_HDR: begin
            if (bus.rx_valid) begin
              if (bus.rx_data == HDR1) begin
                state_q <= S_PAYLOAD;
                idx_q   <= 4'd0;
                sum_q   <= 8'd0;
              end else if (bus.rx_data != HDR0) begin
                state_q <= S_IDLE;
              end
            end
          end

          S_PAYLOAD: begin
            if (bus.rx_valid) begin
              pbuf_q[idx_q] <= bus.rx_data;
              sum_q         <= sum_q + bus.rx_data;
              if (idx_q == LAST_IDX) state_q <= S_CHK;
              else                   idx_q   <= idx_q + 4'd1;
            end
          end

          S_CHK: begin
            if (bus.rx_valid) begin
              if (bus.rx_data == sum_q) begin
                state_q <= S_WAIT;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_IDLE;
              end
            end
          end

          S_WAIT: begin
            if (bus.rx_valid) ovf_err_q <= 1'b1;
            if (bus.wrfifo_usedw <= SPACE_LIMIT) begin
              state_q   <= S_WRITE;
              wr_req_q  <= 1'b1;
              wr_data_q <= pbuf_q[0];
              idx_q     <= 4'd0;
            end
          end

          S_WRITE: begin
            // idx_q tracks the beat currently on the bus; the burst never stalls.
            if (bus.rx_valid) ovf_err_q <= 1'b1;
            if (idx_q == LAST_IDX) begin
              wr_req_q   <= 1'b0;
              wr_data_q  <= 8'd0;
              frame_ok_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              idx_q     <= idx_q + 4'd1;
              wr_data_q <= pbuf_q[idx_q + 4'd1];
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.wrfifo_data = wr_data_q;
  assign bus.wrfifo_req  = wr_req_q;
  assign bus.frame_ok    = frame_ok_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.ovf_err     = ovf_err_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire
